// File: rtl/round_controller_pkg.sv
// round_controller_pkg
//   Shared types and constants for the round sequencer and its neighbours.
//   - state_t   : round sequencer states
//   - winner_t  : round / match result codes (NONE=00, P1=01, P2=10, DRAW=11)
//   - SCORE_W   : score width, shared with the hit-detection block
//   - CNT_W     : width of the pause / restart tick counters
//   - match_result() : picks the match winner once a score has reached the limit
package round_controller_pkg;

  localparam int SCORE_W = 9;
  localparam int CNT_W   = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESTART = 3'd1,
    ARM     = 3'd2,
    PLAY    = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Only meaningful when at least one score has reached win_score.
  // If both have, the higher score wins and a tie is a draw.
  function automatic winner_t match_result(input logic [SCORE_W-1:0] s1,
                                           input logic [SCORE_W-1:0] s2,
                                           input logic [SCORE_W-1:0] win_score);
    winner_t w;
    if ((s1 >= win_score) && (s2 >= win_score)) begin
      if (s1 > s2)      w = WIN_P1;
      else if (s2 > s1) w = WIN_P2;
      else              w = WIN_DRAW;
    end else if (s1 >= win_score) begin
      w = WIN_P1;
    end else begin
      w = WIN_P2;
    end
    return w;
  endfunction

endpackage

// File: rtl/round_controller_tick_down_counter.sv
// tick_down_counter
//   Loadable down-counter with a zero flag. Load wins over decrement; the
//   count holds at zero instead of wrapping.
// Ports:
//   i_clk      : clock
//   i_rst      : synchronous active-high reset (count -> 0)
//   i_load     : load i_load_val this cycle
//   i_load_val : value to load
//   i_dec      : decrement this cycle (ignored while loading or at zero)
//   o_zero     : count is zero
module tick_down_counter
  import round_controller_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/round_controller.sv
// round_controller
//   Sequences a tank match: IDLE -> RESTART -> ARM -> PLAY -> PAUSE ->
//   (RESTART | DONE). Drives the map restart strobe and the movement freeze,
//   and reports round / match results. Every output is registered.
//   Optional feature macro: ROUND_TIMEOUT_EN (round time limit of
//   ROUND_TICKS cycles, timeout ends the round as a draw).
// Ports:
//   clk_19       : game clock (shared with hit detection)
//   rst          : synchronous active-high reset
//   start        : one-cycle start pulse, honoured only in IDLE
//   p1_death     : p1 dead
//   p2_death     : p2 dead
//   p1_score     : p1 score, already updated when a death flag rises
//   p2_score     : p2 score, same timing
//   restart_map  : restart strobe to hit detection and map logic
//   freeze       : tanks and bullets must not move
//   round_winner : result of the last round
//   match_over   : match decided
//   match_winner : winner of the match
//   round_num    : rounds started, saturating at 255
//   dbg_state    : current sequencer state
//
// Handshake: there is no valid/ready pair here. start is a single-cycle
// request that is consumed only in IDLE; restart_map is a level held for
// RESTART_TICKS cycles that the hit-detection block must treat as a clear.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int PAUSE_TICKS   = 64,
  parameter int RESTART_TICKS = 2,
  parameter int WIN_SCORE     = 5,
  parameter int ROUND_TICKS   = 3000
) (
  input  logic               clk_19,
  input  logic               rst,
  input  logic               start,
  input  logic               p1_death,
  input  logic               p2_death,
  input  logic [SCORE_W-1:0] p1_score,
  input  logic [SCORE_W-1:0] p2_score,
  output logic               restart_map,
  output logic               freeze,
  output logic [1:0]         round_winner,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic [7:0]         round_num,
  output logic [2:0]         dbg_state
);

  localparam logic [CNT_W-1:0]   PAUSE_LOAD   = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [CNT_W-1:0]   RESTART_LOAD = CNT_W'(RESTART_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL      = SCORE_W'(WIN_SCORE);

  state_t     r_state;
  state_t     w_state_next;
  winner_t    r_round_winner;
  winner_t    w_round_winner_next;
  winner_t    r_match_winner;
  winner_t    w_match_winner_next;
  logic       r_restart_map;
  logic       r_freeze;
  logic       r_match_over;
  logic [7:0] r_round_num;

  logic w_enter_restart;
  logic w_enter_pause;
  logic w_restart_zero;
  logic w_pause_zero;
  logic w_timeout;

  // ------------------------------------------------------------------
  // Round timer (optional)
  // ------------------------------------------------------------------
`ifdef ROUND_TIMEOUT_EN
  logic [15:0] r_round_timer;

  // Held at zero outside PLAY, so it is cleared on every entry to PLAY.
  always_ff @(posedge clk_19) begin
    if (rst || (r_state != PLAY)) begin
      r_round_timer <= '0;
    end else begin
      r_round_timer <= r_round_timer + 16'd1;
    end
  end

  assign w_timeout = (r_state == PLAY) && (r_round_timer == 16'(ROUND_TICKS - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Tick counters
  // ------------------------------------------------------------------
  assign w_enter_restart = (w_state_next == RESTART) && (r_state != RESTART);
  assign w_enter_pause   = (w_state_next == PAUSE) && (r_state != PAUSE);

  tick_down_counter u_restart_cnt (
    .i_clk      (clk_19),
    .i_rst      (rst),
    .i_load     (w_enter_restart),
    .i_load_val (RESTART_LOAD),
    .i_dec      (r_state == RESTART),
    .o_zero     (w_restart_zero)
  );

  tick_down_counter u_pause_cnt (
    .i_clk      (clk_19),
    .i_rst      (rst),
    .i_load     (w_enter_pause),
    .i_load_val (PAUSE_LOAD),
    .i_dec      (r_state == PAUSE),
    .o_zero     (w_pause_zero)
  );

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_next        = r_state;
    w_round_winner_next = r_round_winner;
    w_match_winner_next = r_match_winner;

    case (r_state)
      IDLE: begin
        if (start) w_state_next = RESTART;
      end

      RESTART: begin
        if (w_restart_zero) w_state_next = ARM;
      end

      // Waits for the death flops to be seen clear so a death left over
      // from the previous round cannot end the new one immediately.
      ARM: begin
        if (!p1_death && !p2_death) w_state_next = PLAY;
      end

      // A death on the timeout cycle is a real result and takes priority.
      PLAY: begin
        if (p1_death || p2_death) begin
          w_state_next = PAUSE;
          if (p1_death && p2_death) w_round_winner_next = WIN_DRAW;
          else if (p1_death)        w_round_winner_next = WIN_P2;
          else                      w_round_winner_next = WIN_P1;
        end else if (w_timeout) begin
          w_state_next        = PAUSE;
          w_round_winner_next = WIN_DRAW;
        end
      end

      // Scores are judged at the end of the pause, once the hit-detection
      // block has long since settled its counts.
      PAUSE: begin
        if (w_pause_zero) begin
          if ((p1_score >= WIN_VAL) || (p2_score >= WIN_VAL)) begin
            w_state_next        = DONE;
            w_match_winner_next = match_result(p1_score, p2_score, WIN_VAL);
          end else begin
            w_state_next = RESTART;
          end
        end
      end

      DONE: begin
        w_state_next = DONE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State and registered outputs (outputs follow the next state so they
  // line up with the state they describe)
  // ------------------------------------------------------------------
  always_ff @(posedge clk_19) begin
    if (rst) begin
      r_state        <= IDLE;
      r_restart_map  <= 1'b0;
      r_freeze       <= 1'b1;
      r_round_winner <= WIN_NONE;
      r_match_over   <= 1'b0;
      r_match_winner <= WIN_NONE;
      r_round_num    <= 8'd0;
    end else begin
      r_state        <= w_state_next;
      r_restart_map  <= (w_state_next == RESTART);
      r_freeze       <= (w_state_next != PLAY);
      r_round_winner <= w_round_winner_next;
      r_match_over   <= (w_state_next == DONE);
      r_match_winner <= w_match_winner_next;
      if (w_enter_restart && (r_round_num != 8'hFF)) begin
        r_round_num <= r_round_num + 8'd1;
      end
    end
  end

  assign restart_map  = r_restart_map;
  assign freeze       = r_freeze;
  assign round_winner = r_round_winner;
  assign match_over   = r_match_over;
  assign match_winner = r_match_winner;
  assign round_num    = r_round_num;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller
//   Directed bench for round_controller. The driver pushes each expected
//   output change (cycle stamp + output bundle) into exp_q; the monitor
//   pops one entry every time the registered output bundle changes.
module tb_round_controller;

  localparam int W = 31;  // {cycle[15:0], bundle[14:0]}

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] P1   = 2'b01;
  localparam logic [1:0] P2   = 2'b10;
  localparam logic [1:0] DRAW = 2'b11;

  // ---------------- clock / reset ----------------
  logic       clk_19   = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       p1_death = 1'b0;
  logic       p2_death = 1'b0;
  logic [8:0] p1_score = 9'd0;
  logic [8:0] p2_score = 9'd0;

  logic       restart_map;
  logic       freeze;
  logic [1:0] round_winner;
  logic       match_over;
  logic [1:0] match_winner;
  logic [7:0] round_num;
  logic [2:0] dbg_state;

  always #5 clk_19 = ~clk_19;

  int cyc = 0;
  always @(posedge clk_19) cyc <= cyc + 1;

  round_controller #(
    .PAUSE_TICKS   (64),
    .RESTART_TICKS (2),
    .WIN_SCORE     (5),
    .ROUND_TICKS   (10)
  ) dut (
    .clk_19       (clk_19),
    .rst          (rst),
    .start        (start),
    .p1_death     (p1_death),
    .p2_death     (p2_death),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .restart_map  (restart_map),
    .freeze       (freeze),
    .round_winner (round_winner),
    .match_over   (match_over),
    .match_winner (match_winner),
    .round_num    (round_num),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [1:0]   rw_exp = NONE;
  logic [7:0]   rn_exp = 8'd0;

  function automatic logic [14:0] mk(input logic rm, input logic fz,
                                     input logic [1:0] rw, input logic mo,
                                     input logic [1:0] mw, input logic [7:0] rn);
    return {rm, fz, rw, mo, mw, rn};
  endfunction

  function automatic logic [7:0] rn_inc(input logic [7:0] rn);
    return (rn == 8'hFF) ? 8'hFF : rn + 8'd1;
  endfunction

  task automatic push(input int at, input logic [14:0] b);
    logic [15:0] at16;
    at16 = at[15:0];
    exp_q.push_back({at16, b});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_19);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [14:0] prev_b = 'x;
  always @(negedge clk_19) begin
    logic [14:0] cur;
    logic [W-1:0] e;
    logic [15:0] c16;
    cur = {restart_map, freeze, round_winner, match_over, match_winner, round_num};
    c16 = cyc[15:0];
    if (cur !== prev_b) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_change cyc=%0d got=%h (no change expected)", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e !== {c16, cur}) begin
          n_err = n_err + 1;
          $display("FAIL out_change got cyc=%0d bundle=%h, required cyc=%0d bundle=%h",
                   cyc, cur, e[30:15], e[14:0]);
        end
      end
      prev_b = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    push(cyc + 1, mk(1'b0, 1'b1, NONE, 1'b0, NONE, 8'd0));
    rst = 1'b1; p1_death = 1'b0; p2_death = 1'b0; p1_score = '0; p2_score = '0;
    tick(1);
    rst = 1'b0; rn_exp = 8'd0; rw_exp = NONE;
    tick(2);
  endtask

  // From IDLE: restart pulse of 2 cycles, ARM, then PLAY. Returns one cycle
  // after PLAY was entered.
  task automatic do_start();
    int n;
    n = cyc;
    start = 1'b1;
    rn_exp = rn_inc(rn_exp);
    push(n + 1, mk(1'b1, 1'b1, rw_exp, 1'b0, NONE, rn_exp));
    push(n + 3, mk(1'b0, 1'b1, rw_exp, 1'b0, NONE, rn_exp));
    push(n + 4, mk(1'b0, 1'b0, rw_exp, 1'b0, NONE, rn_exp));
    tick(1);
    start = 1'b0;
    tick(4);
  endtask

  // From PLAY: a death ends the round, 64-cycle pause, then the next round.
  task automatic death_round(input logic d1, input logic d2,
                             input logic [8:0] s1, input logic [8:0] s2,
                             input logic [1:0] rw);
    int m;
    m = cyc;
    p1_death = d1; p2_death = d2; p1_score = s1; p2_score = s2;
    rw_exp = rw;
    push(m + 1, mk(1'b0, 1'b1, rw, 1'b0, NONE, rn_exp));
    rn_exp = rn_inc(rn_exp);
    push(m + 65, mk(1'b1, 1'b1, rw, 1'b0, NONE, rn_exp));
    push(m + 67, mk(1'b0, 1'b1, rw, 1'b0, NONE, rn_exp));
    push(m + 68, mk(1'b0, 1'b0, rw, 1'b0, NONE, rn_exp));
    tick(66);
    p1_death = 1'b0; p2_death = 1'b0;
    tick(3);
  endtask

  // From PLAY: the death that decides the match, then start pulses and
  // death toggles that must all be ignored in DONE.
  task automatic match_end(input logic d1, input logic d2,
                           input logic [8:0] s1, input logic [8:0] s2,
                           input logic [1:0] rw, input logic [1:0] mw);
    int t;
    t = cyc;
    p1_death = d1; p2_death = d2; p1_score = s1; p2_score = s2;
    rw_exp = rw;
    push(t + 1,  mk(1'b0, 1'b1, rw, 1'b0, NONE, rn_exp));
    push(t + 65, mk(1'b0, 1'b1, rw, 1'b1, mw, rn_exp));
    tick(66);
    p1_death = 1'b0; p2_death = 1'b0;
    repeat (3) begin
      start = 1'b1; tick(1); start = 1'b0; tick(3);
    end
    p2_death = 1'b1; tick(2); p2_death = 1'b0; tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int q;
    push(1, mk(1'b0, 1'b1, NONE, 1'b0, NONE, 8'd0));
    tick(3);
    rst = 1'b0;
    tick(1);

    // First round: restart pulse, round_num=1, PLAY with deaths clear.
    do_start();

`ifdef ROUND_TIMEOUT_EN
    begin
      int e, e2;
      e = cyc - 1;  // PLAY entered on edge e
      rw_exp = DRAW;
      push(e + 10, mk(1'b0, 1'b1, DRAW, 1'b0, NONE, rn_exp));
      rn_exp = rn_inc(rn_exp);
      push(e + 74, mk(1'b1, 1'b1, DRAW, 1'b0, NONE, rn_exp));
      push(e + 76, mk(1'b0, 1'b1, DRAW, 1'b0, NONE, rn_exp));
      push(e + 77, mk(1'b0, 1'b0, DRAW, 1'b0, NONE, rn_exp));
      tick(e + 77 - cyc);
      e2 = cyc;
      // Death lands exactly on the expiry cycle: death decides the round.
      tick(9);
      p1_death = 1'b1;
      rw_exp = P2;
      push(e2 + 10, mk(1'b0, 1'b1, P2, 1'b0, NONE, rn_exp));
      rn_exp = rn_inc(rn_exp);
      push(e2 + 74, mk(1'b1, 1'b1, P2, 1'b0, NONE, rn_exp));
      push(e2 + 76, mk(1'b0, 1'b1, P2, 1'b0, NONE, rn_exp));
      push(e2 + 77, mk(1'b0, 1'b0, P2, 1'b0, NONE, rn_exp));
      tick(65);
      p1_death = 1'b0;
      tick(e2 + 78 - cyc);
    end
`else
    // Without the timer PLAY continues indefinitely: no output change.
    tick(20);
`endif

    // p2 dies with p1_score=1: round to P1, pause, restart, next round.
    death_round(1'b0, 1'b1, 9'd1, 9'd0, P1);

    // Stale p1 death held through ARM keeps the game frozen.
    q = cyc;
    p1_death = 1'b1; p2_score = 9'd1;
    rw_exp = P2;
    push(q + 1, mk(1'b0, 1'b1, P2, 1'b0, NONE, rn_exp));
    rn_exp = rn_inc(rn_exp);
    push(q + 65, mk(1'b1, 1'b1, P2, 1'b0, NONE, rn_exp));
    push(q + 67, mk(1'b0, 1'b1, P2, 1'b0, NONE, rn_exp));
    push(q + 73, mk(1'b0, 1'b0, P2, 1'b0, NONE, rn_exp));
    tick(72);
    p1_death = 1'b0;
    tick(2);

    // Both die: DRAW; then reset while restart_map is high.
    begin
      int r;
      r = cyc;
      p1_death = 1'b1; p2_death = 1'b1; p1_score = 9'd2; p2_score = 9'd2;
      push(r + 1, mk(1'b0, 1'b1, DRAW, 1'b0, NONE, rn_exp));
      push(r + 65, mk(1'b1, 1'b1, DRAW, 1'b0, NONE, rn_inc(rn_exp)));
      tick(65);
      do_reset();
    end

    // Match to p2 at score 5; start ignored in DONE.
    do_start();
    match_end(1'b1, 1'b0, 9'd0, 9'd5, P2, P2);
    do_reset();

    // Both over the limit: higher score wins.
    do_start();
    match_end(1'b1, 1'b1, 9'd6, 9'd5, DRAW, P1);
    do_reset();

    // Both over the limit and equal: match drawn.
    do_start();
    match_end(1'b1, 1'b1, 9'd5, 9'd5, DRAW, DRAW);
    do_reset();

    // p1 reaches exactly the limit.
    do_start();
    match_end(1'b0, 1'b1, 9'd5, 9'd4, P1, P1);
    do_reset();

    // round_num saturates at 255.
    do_start();
    repeat (255) death_round(1'b1, 1'b0, 9'd0, 9'd0, P2);

    tick(5);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL missing_change got none, required cyc=%0d bundle=%h", e[30:15], e[14:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Consumes the p1_death/p2_death state and the scores produced by the hit-detection block.
- Sequences each round: play, post-death pause, map restart, next round. Declares the match winner.
- Drives restart_map back into the hit-detection block, which uses it to clear its death flops, and into the map/tank logic.
- Drives freeze to the tank and bullet movement logic.

Parameters:
- PAUSE_TICKS, 64: clk_19 cycles frozen after a death before the restart. Legal range 1..511.
- RESTART_TICKS, 2: cycles restart_map is held high. Range 1..7.
- WIN_SCORE, 5: score (9-bit compare) that ends the match.
- ROUND_TICKS, 3000: round time limit in cycles. Used only with ROUND_TIMEOUT_EN.

Ports:
- clk_19  in  1  game clock, the same clock the hit-detection block uses.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse from the debounced start button.
- p1_death  in  1  1 = p1 dead.
- p2_death  in  1  1 = p2 dead.
- p1_score  in  9  p1 score. It is already incremented on the same edge that p1_death/p2_death rises.
- p2_score  in  9  p2 score, same timing.
- restart_map  out  1  registered restart strobe; resets the death flops and the map.
- freeze  out  1  1 = tanks and bullets must not move.
- round_winner  out  2  result of the last round (see codes).
- match_over  out  1  1 = match decided.
- match_winner  out  2  winner of the match (see codes).
- round_num  out  8  number of rounds started; saturates at 255.

Behaviour:
- Reset values: restart_map=0, freeze=1, round_winner=NONE, match_over=0, match_winner=NONE, round_num=0. State=IDLE and all counters=0.
- Winner codes: NONE=00, P1=01, P2=10, DRAW=11.
- All outputs are registered; none is combinational from the inputs.
- IDLE: freeze=1. On start go to RESTART and load the restart counter with RESTART_TICKS-1.
- RESTART:
  - restart_map=1 and freeze=1 for exactly RESTART_TICKS cycles.
  - Exit to ARM with restart_map=0 on the next edge.
  - round_num increments once, on entry.
- ARM: freeze=1. Go to PLAY on the first cycle with p1_death==0 and p2_death==0, so stale deaths cannot re-trigger a round.
- PLAY: freeze=0. On a cycle where p1_death|p2_death==1, go to PAUSE on the next edge. That same edge also:
  - sets freeze=1,
  - latches round_winner: p1 dead only -> P2; p2 dead only -> P1; both dead -> DRAW,
  - loads the pause counter with PAUSE_TICKS-1.
- PAUSE:
  - The counter decrements every cycle.
  - When the counter reaches 0, compare the scores, sampled on that cycle:
    - if p1_score>=WIN_SCORE or p2_score>=WIN_SCORE, go to DONE;
    - otherwise go to RESTART.
  - If both scores are >= WIN_SCORE, the higher score wins; equal scores give DRAW.
- DONE: freeze=1, match_over=1, match_winner latched on entry. DONE is terminal until rst; start is ignored.
- start is ignored in every state except IDLE.
- rst has priority on any cycle, including mid-RESTART. restart_map drops to 0 on the next edge.
- Death inputs are ignored outside PLAY and ARM.
- round_num does not wrap; it holds at 255.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- When defined:
  - A 16-bit round timer clears on entry to PLAY and increments each PLAY cycle.
  - When it reaches ROUND_TICKS-1 with no death, go to PAUSE with round_winner=DRAW. Scores are unchanged.
  - A death on the same cycle as expiry takes priority over the timeout.
- When undefined: no timer logic exists, and PLAY lasts until a death.

Decomposition:
- Shared package holds:
  - state encodings: IDLE, RESTART, ARM, PLAY, PAUSE, DONE;
  - winner codes: WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW;
  - the 9-bit score width constant, which the hit-detection block also uses.
- One natural sub-module: tick_down_counter.
  - Loadable 9-bit down-counter with a zero flag.
  - Instanced for the pause count and the restart count.

Test Plan:
1. rst, then start pulse -> restart_map=1 for exactly 2 cycles, round_num=1, freeze=0 in PLAY once both deaths are 0.
2. In PLAY, assert p2_death with p1_score=1 -> next edge freeze=1 and round_winner=P1. After 64 cycles restart_map pulses for 2 cycles, round_num=2, then PLAY resumes.
3. Hold p1_death=1 through ARM (stale death) -> stays in ARM with freeze=1. Release -> PLAY on the next edge.
4. p1_death with p2_score=5 -> after the 64-cycle pause: match_over=1, match_winner=P2, no restart_map pulse, later start pulses ignored.
5. Both deaths high together -> round_winner=DRAW. Assert rst while restart_map=1 -> all outputs at reset values on the next edge.
6. ROUND_TIMEOUT_EN, ROUND_TICKS=10, no deaths -> PAUSE after 10 PLAY cycles with round_winner=DRAW, scores untouched. With a death on the expiry cycle -> winner decided by the death.
